// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: allocates IDs, collects out-of-order
// writebacks, retires in program order and answers operand lookups.
module issue_scoreboard #(
    parameter  int NR_ENTRIES    = 4,
    parameter  int NR_WB_PORTS   = 4,
    parameter  int XLEN          = 64,
    localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 issue_valid_i,
    output logic                                 issue_ready_o,
    input  logic [4:0]                           issue_rd_i,
    output logic [TRANS_ID_BITS-1:0]             issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS*XLEN-1:0]          wb_result_i,
    input  logic [NR_WB_PORTS-1:0]               wb_ex_i,
    output logic                                 commit_valid_o,
    input  logic                                 commit_ack_i,
    output logic [TRANS_ID_BITS-1:0]             commit_trans_id_o,
    output logic [4:0]                           commit_rd_o,
    output logic [XLEN-1:0]                      commit_result_o,
    output logic                                 commit_ex_o,
    input  logic [4:0]                           rs1_i,
    input  logic [4:0]                           rs2_i,
    output logic                                 rs1_busy_o,
    output logic                                 rs2_busy_o,
    output logic                                 rs1_fwd_o,
    output logic                                 rs2_fwd_o,
    output logic [XLEN-1:0]                      rs1_value_o,
    output logic [XLEN-1:0]                      rs2_value_o,
    output logic [TRANS_ID_BITS:0]               count_o
);

    localparam int TB = TRANS_ID_BITS;
    localparam int CW = TRANS_ID_BITS + 1;

    logic [NR_ENTRIES-1:0] busy_q;
    logic [NR_ENTRIES-1:0] done_q;
    logic [NR_ENTRIES-1:0] ex_q;
    logic [4:0]            rd_q  [NR_ENTRIES];
    logic [XLEN-1:0]       res_q [NR_ENTRIES];
    logic [TB-1:0]         head_q;
    logic [TB-1:0]         tail_q;
    logic [CW-1:0]         count_q;

    logic [TB-1:0]   wb_id  [NR_WB_PORTS];
    logic [XLEN-1:0] wb_res [NR_WB_PORTS];

    logic issue_fire;
    logic commit_fire;

    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb
        assign wb_id[p]  = wb_trans_id_i[p*TB +: TB];
        assign wb_res[p] = wb_result_i[p*XLEN +: XLEN];
    end

    assign issue_ready_o    = !flush_i && (count_q < CW'(NR_ENTRIES));
    assign issue_trans_id_o = tail_q;
    assign issue_fire       = issue_valid_i && issue_ready_o;

    assign commit_valid_o    = !flush_i && busy_q[head_q] && done_q[head_q];
    assign commit_trans_id_o = head_q;
    assign commit_rd_o       = rd_q[head_q];
    assign commit_result_o   = res_q[head_q];
    assign commit_ex_o       = ex_q[head_q];
    assign commit_fire       = commit_valid_o && commit_ack_i;

    assign count_o = count_q;

    // Walk entries oldest to youngest so the youngest match is kept.
    function automatic logic [XLEN+1:0] lookup(input logic [4:0] rs);
        logic          hit;
        logic          dn;
        logic [XLEN-1:0] val;
        logic [TB-1:0] idx;
        hit = 1'b0;
        dn  = 1'b0;
        val = '0;
        for (int a = 0; a < NR_ENTRIES; a++) begin
            idx = head_q + TB'(a);
            if (busy_q[idx] && rd_q[idx] == rs) begin
                hit = 1'b1;
                dn  = done_q[idx];
                val = res_q[idx];
            end
        end
        if (rs == 5'd0 || !hit) return '0;
        return {!dn, dn, dn ? val : '0};
    endfunction

    // Per-operand busy/forward lookup against in-flight entries.
    always_comb begin
        {rs1_busy_o, rs1_fwd_o, rs1_value_o} = lookup(rs1_i);
        {rs2_busy_o, rs2_fwd_o, rs2_value_o} = lookup(rs2_i);
    end

    // Entry state, pointers and occupancy; later ports override earlier.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            ex_q    <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                rd_q[i]  <= '0;
                res_q[i] <= '0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && busy_q[wb_id[p]]) begin
                    done_q[wb_id[p]] <= 1'b1;
                    res_q[wb_id[p]]  <= wb_res[p];
                    ex_q[wb_id[p]]   <= wb_ex_i[p];
                end
            end
            if (commit_fire) begin
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
                head_q         <= head_q + TB'(1);
            end
            if (issue_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                rd_q[tail_q]   <= issue_rd_i;
                res_q[tail_q]  <= '0;
                ex_q[tail_q]   <= 1'b0;
                tail_q         <= tail_q + TB'(1);
            end
            count_q <= count_q + CW'(issue_fire) - CW'(commit_fire);
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed vector bench for issue_scoreboard (default parameters).
module tb_issue_scoreboard;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         iv;
    logic         rdy;
    logic [4:0]   rd;
    logic [1:0]   tid;
    logic [3:0]   wbv;
    logic [7:0]   wbid;
    logic [255:0] wbres;
    logic [3:0]   wbex;
    logic         cv;
    logic         ack;
    logic [1:0]   ctid;
    logic [4:0]   crd;
    logic [63:0]  cres;
    logic         cex;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic         b1;
    logic         b2;
    logic         f1;
    logic         f2;
    logic [63:0]  v1;
    logic [63:0]  v2;
    logic [2:0]   cnt;

    int nvec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .issue_valid_i    (iv),
        .issue_ready_o    (rdy),
        .issue_rd_i       (rd),
        .issue_trans_id_o (tid),
        .wb_valid_i       (wbv),
        .wb_trans_id_i    (wbid),
        .wb_result_i      (wbres),
        .wb_ex_i          (wbex),
        .commit_valid_o   (cv),
        .commit_ack_i     (ack),
        .commit_trans_id_o(ctid),
        .commit_rd_o      (crd),
        .commit_result_o  (cres),
        .commit_ex_o      (cex),
        .rs1_i            (rs1),
        .rs2_i            (rs2),
        .rs1_busy_o       (b1),
        .rs2_busy_o       (b2),
        .rs1_fwd_o        (f1),
        .rs2_fwd_o        (f2),
        .rs1_value_o      (v1),
        .rs2_value_o      (v2),
        .count_o          (cnt)
    );

    typedef struct {
        logic        rst, flush, iv;
        logic [4:0]  rd;
        logic [3:0]  wbv;
        logic [7:0]  wbid;
        logic [63:0] wbres;
        logic [3:0]  wbex;
        logic        ack;
        logic [4:0]  rs1, rs2;
        logic        e_rdy;
        logic [1:0]  e_tid;
        logic        e_cv;
        logic [1:0]  e_ctid;
        logic [4:0]  e_crd;
        logic [15:0] e_cres;
        logic        e_cex;
        logic        e_b1, e_f1;
        logic [15:0] e_v1;
        logic        e_b2, e_f2;
        logic [15:0] e_v2;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic r, input logic fl, input logic i, input logic [4:0] d,
        input logic [3:0] wv, input logic [7:0] wi, input logic [63:0] wr,
        input logic [3:0] we, input logic a, input logic [4:0] s1, input logic [4:0] s2,
        input logic er, input logic [1:0] et, input logic ec, input logic [1:0] ect,
        input logic [4:0] ecr, input logic [15:0] ecs, input logic ee,
        input logic eb1, input logic ef1, input logic [15:0] ev1,
        input logic eb2, input logic ef2, input logic [15:0] ev2, input logic [2:0] en);
        vec_t t;
        t.rst = r; t.flush = fl; t.iv = i; t.rd = d;
        t.wbv = wv; t.wbid = wi; t.wbres = wr; t.wbex = we;
        t.ack = a; t.rs1 = s1; t.rs2 = s2;
        t.e_rdy = er; t.e_tid = et; t.e_cv = ec; t.e_ctid = ect;
        t.e_crd = ecr; t.e_cres = ecs; t.e_cex = ee;
        t.e_b1 = eb1; t.e_f1 = ef1; t.e_v1 = ev1;
        t.e_b2 = eb2; t.e_f2 = ef2; t.e_v2 = ev2; t.e_cnt = en;
        return t;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    task automatic idle();
        rst = 0; flush = 0; iv = 0; rd = 0; ack = 0;
        wbv = 0; wbid = 0; wbres = 0; wbex = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic apply(input vec_t t, input int n);
        logic [210:0] act;
        logic [210:0] exp;
        rst = t.rst; flush = t.flush; iv = t.iv; rd = t.rd;
        wbv = t.wbv; wbid = t.wbid; wbex = t.wbex; ack = t.ack;
        rs1 = t.rs1; rs2 = t.rs2;
        for (int p = 0; p < 4; p++)
            wbres[p*64 +: 64] = {48'h0, t.wbres[p*16 +: 16]};
        @(negedge clk);
        act = {rdy, tid, cv, ctid, crd, cres, cex, b1, f1, v1, b2, f2, v2, cnt};
        exp = {t.e_rdy, t.e_tid, t.e_cv, t.e_ctid, t.e_crd, 48'h0, t.e_cres,
               t.e_cex, t.e_b1, t.e_f1, 48'h0, t.e_v1,
               t.e_b2, t.e_f2, 48'h0, t.e_v2, t.e_cnt};
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL vec%0d: got %h want %h", n, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst fl iv rd  wbv  wbid   wbres                   wbex ack rs1 rs2 | rdy tid cv ctid crd cres  cex b1 f1 v1     b2 f2 v2 cnt
        tbl[0]  = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,0,0,0,0,  16'h0,  0, 0,0,16'h0,  0,0,0, 0);
        tbl[1]  = mk(0,0,1,1,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,0,0,0,0,  16'h0,  0, 0,0,16'h0,  0,0,0, 0);
        tbl[2]  = mk(0,0,1,2,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,1,0,0,1,  16'h0,  0, 0,0,16'h0,  0,0,0, 1);
        tbl[3]  = mk(0,0,1,3,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,2,0,0,1,  16'h0,  0, 0,0,16'h0,  0,0,0, 2);
        tbl[4]  = mk(0,0,1,4,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,3,0,0,1,  16'h0,  0, 0,0,16'h0,  0,0,0, 3);
        tbl[5]  = mk(0,0,1,5,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  0,0,0,0,1,  16'h0,  0, 0,0,16'h0,  0,0,0, 4);
        tbl[6]  = mk(0,0,0,0,  4'h1,  8'h02, 64'hAA,                 0, 1, 3, 0,  0,0,0,0,1,  16'h0,  0, 1,0,16'h0,  0,0,0, 4);
        tbl[7]  = mk(0,0,0,0,  4'h2,  8'h00, 64'h0000_0000_00BB_0000,0, 0, 3, 0,  0,0,0,0,1,  16'h0,  0, 0,1,16'hAA, 0,0,0, 4);
        tbl[8]  = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 0, 1, 0,  0,0,1,0,1,  16'hBB, 0, 0,1,16'hBB, 0,0,0, 4);
        tbl[9]  = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 1, 1, 0,  0,0,1,0,1,  16'hBB, 0, 0,1,16'hBB, 0,0,0, 4);
        tbl[10] = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 1, 1, 2,  1,0,0,1,2,  16'h0,  0, 0,0,16'h0,  1,0,0, 3);
        tbl[11] = mk(0,0,1,6,  4'h9,  8'h41, 64'h0003_0000_0000_0001,0, 0, 0, 0,  1,0,0,1,2,  16'h0,  0, 0,0,16'h0,  0,0,0, 3);
        tbl[12] = mk(0,0,1,7,  0,     8'h00, 64'h0,                  0, 1, 0, 0,  0,1,1,1,2,  16'h3,  0, 0,0,16'h0,  0,0,0, 4);
        tbl[13] = mk(0,0,1,7,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,1,1,2,3,  16'hAA, 0, 0,0,16'h0,  0,0,0, 3);
        tbl[14] = mk(0,1,1,9,  4'h1,  8'h03, 64'h77,                 0, 1, 0, 0,  0,2,0,2,3,  16'hAA, 0, 0,0,16'h0,  0,0,0, 4);
        tbl[15] = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 0, 6, 0,  1,0,0,0,6,  16'h0,  0, 0,0,16'h0,  0,0,0, 0);
        tbl[16] = mk(0,0,1,5,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,0,0,0,6,  16'h0,  0, 0,0,16'h0,  0,0,0, 0);
        tbl[17] = mk(0,0,1,5,  0,     8'h00, 64'h0,                  0, 0, 5, 0,  1,1,0,0,5,  16'h0,  0, 1,0,16'h0,  0,0,0, 1);
        tbl[18] = mk(0,0,0,0,  4'h4,  8'h00, 64'h0000_0011_0000_0000,4'h4,0, 5, 0,  1,2,0,0,5,  16'h0,  0, 1,0,16'h0,  0,0,0, 2);
        tbl[19] = mk(0,0,0,0,  4'h3,  8'h07, 64'h0000_0000_0022_0099,0, 0, 5, 0,  1,2,1,0,5,  16'h11, 1, 1,0,16'h0,  0,0,0, 2);
        tbl[20] = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 1, 5, 4,  1,2,1,0,5,  16'h11, 1, 0,1,16'h22, 0,0,0, 2);
        tbl[21] = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 1, 5, 0,  1,2,1,1,5,  16'h22, 0, 0,1,16'h22, 0,0,0, 1);
        tbl[22] = mk(0,0,1,8,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,2,0,2,3,  16'hAA, 0, 0,0,16'h0,  0,0,0, 0);
        tbl[23] = mk(0,0,0,0,  4'h1,  8'h02, 64'h55,                 0, 0, 0, 0,  1,3,0,2,8,  16'h0,  0, 0,0,16'h0,  0,0,0, 1);
        tbl[24] = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 1, 0, 0,  1,3,1,2,8,  16'h55, 0, 0,0,16'h0,  0,0,0, 1);
        tbl[25] = mk(0,0,1,9,  0,     8'h00, 64'h0,                  0, 0, 0, 0,  1,3,0,3,4,  16'h0,  0, 0,0,16'h0,  0,0,0, 0);
        tbl[26] = mk(1,0,1,10, 0,     8'h00, 64'h0,                  0, 1, 9, 0,  1,0,0,3,9,  16'h0,  0, 1,0,16'h0,  0,0,0, 1);
        tbl[27] = mk(0,0,0,0,  0,     8'h00, 64'h0,                  0, 0, 9, 0,  1,0,0,0,0,  16'h0,  0, 0,0,16'h0,  0,0,0, 0);

        idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle();

        for (int n = 0; n < NV; n++) apply(tbl[n], n);

        // Fill, complete all four through all ports at once, drain in order.
        for (int k = 0; k < 4; k++) begin
            idle();
            iv = 1;
            rd = 5'(11 + k);
            @(negedge clk);
            chk("fill_tid", 64'(tid), 64'(k));
            @(posedge clk);
            #1;
        end
        idle();
        wbv = 4'hF;
        for (int p = 0; p < 4; p++) begin
            wbid[p*2 +: 2]   = 2'(3 - p);
            wbres[p*64 +: 64] = 64'h1000 + 64'((3 - p) * 'h11);
        end
        @(negedge clk);
        chk("fill_cnt", 64'(cnt), 64'd4);
        chk("fill_cv", 64'(cv), 64'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            idle();
            ack = 1;
            @(negedge clk);
            chk("drain_cv", 64'(cv), 64'd1);
            chk("drain_tid", 64'(ctid), 64'(k));
            chk("drain_rd", 64'(crd), 64'(11 + k));
            chk("drain_res", cres, 64'h1000 + 64'(k * 'h11));
            @(posedge clk);
            #1;
        end
        idle();
        @(negedge clk);
        chk("drain_cnt", 64'(cnt), 64'd0);
        chk("drain_rdy", 64'(rdy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Parametrised in-order scoreboard between the issue and commit stages. Generalises the fixed 4-entry, 4-writeback-port configuration to any power-of-two depth and any number of writeback ports.
- Allocates a transaction ID per issued instruction and collects out-of-order writebacks by ID.
- Retires entries strictly in program order.
- Provides per-source-operand lookup (busy / forwardable) for the issue stage.

Parameters:
- NR_ENTRIES, 4: scoreboard depth; power of two, ≥2.
- NR_WB_PORTS, 4: number of writeback ports, ≥1.
- XLEN, 64: result width.
- TRANS_ID_BITS, $clog2(NR_ENTRIES): derived, not overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  discard all in-flight entries
- issue_valid_i  in  1  issue request
- issue_ready_o  out  1  entry free
- issue_rd_i  in  5  destination register
- issue_trans_id_o  out  TRANS_ID_BITS  ID that will be allocated (tail pointer)
- wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe
- wb_trans_id_i  in  NR_WB_PORTS*TRANS_ID_BITS  per-port target ID, port p at slice p
- wb_result_i  in  NR_WB_PORTS*XLEN  per-port result
- wb_ex_i  in  NR_WB_PORTS  per-port exception flag
- commit_valid_o  out  1  head entry done
- commit_ack_i  in  1  commit stage consumes head
- commit_trans_id_o  out  TRANS_ID_BITS  head ID
- commit_rd_o  out  5  head rd
- commit_result_o  out  XLEN  head result
- commit_ex_o  out  1  head exception flag
- rs1_i, rs2_i  in  5 each  source registers to look up
- rs1_busy_o, rs2_busy_o  out  1 each  youngest matching entry in flight and not done
- rs1_fwd_o, rs2_fwd_o  out  1 each  youngest matching entry done; value valid
- rs1_value_o, rs2_value_o  out  XLEN each  forwarded value
- count_o  out  TRANS_ID_BITS+1  occupied entries

Behaviour:
- State per entry: busy, done, rd, result, ex. Also head pointer, tail pointer (mod NR_ENTRIES) and count.
- Reset (rst_i=1 at a clock edge): head=tail=count=0; all busy/done cleared; result/rd/ex cleared.
  - After reset: issue_ready_o=1, commit_valid_o=0, all rs*_busy_o/rs*_fwd_o=0, commit_* data=0, issue_trans_id_o=0.
  - Reset mid-operation discards everything; it overrides flush and all handshakes.
- Issue:
  - issue_ready_o = !flush_i && (count < NR_ENTRIES). Does not depend on commit_ack_i (no same-cycle slot reuse when full).
  - On issue_valid_i && issue_ready_o, entry[tail] is written with busy=1, done=0, rd=issue_rd_i, ex=0, result=0; tail increments.
  - issue_trans_id_o equals tail, combinationally.
- Writeback:
  - Each port p with wb_valid_i[p] sets entry[id].done=1, result, ex at the clock edge.
  - A writeback to a non-busy entry is ignored.
  - Two ports targeting the same ID in one cycle: the highest port index wins.
  - A writeback is visible on commit/forward outputs the cycle after it is presented. There is no combinational wb→commit or wb→forward bypass.
- Commit:
  - commit_valid_o = !flush_i && entry[head].busy && entry[head].done. commit_* data reflects entry[head] at all times.
  - On commit_valid_o && commit_ack_i: entry[head].busy=0, done=0, head increments.
  - An ack without valid is ignored.
- Count: count_next = count + issue_fire − commit_fire. Simultaneous issue and commit leaves count unchanged.
- Flush:
  - Takes priority over issue, writeback and commit in the same cycle; all three are dropped.
  - Next cycle: head=tail=count=0 and all busy/done cleared.
- Operand lookup (combinational, per rsX):
  - If rsX=0 or no busy entry has rd==rsX: busy=0, fwd=0, value=0.
  - Otherwise select the youngest matching busy entry, by age relative to head.
    - Selected entry done=1: fwd=1, value=its result.
    - Selected entry not done: busy=1.
- Wrap-around: head and tail wrap from NR_ENTRIES−1 to 0. Trans IDs repeat modulo NR_ENTRIES. Full when count==NR_ENTRIES, empty when count==0; head==tail in both cases.

Test Plan:
- Reset, then issue 4 instrs (rd=1,2,3,4) with default params → IDs 0,1,2,3 returned; count_o=4; issue_ready_o=0 on cycle 5.
- Writeback ID2 then ID0 (result 0xAA, 0xBB) → commit_valid_o rises only after ID0 lands. Commit order: ID0 (0xBB, rd=1), then ID1 is blocked until written back.
- Full scoreboard, commit_ack_i and issue_valid_i high together → commit fires, issue refused that cycle, count_o=3; next cycle issue accepted with ID0 (wrap).
- Issue rd=5 twice (IDs 0,1); writeback ID0=0x11 only; rs1_i=5 → rs1_busy_o=1 (ID1 youngest). After ID1 writeback 0x22 → rs1_fwd_o=1, rs1_value_o=0x22. rs2_i=0 → both flags 0.
- Ports 0 and 3 both write ID1 (0x1, 0x3) in the same cycle → stored result 0x3. Writeback to a free ID → no change.
- Flush asserted with 3 in flight plus simultaneous issue/commit → next cycle count_o=0, commit_valid_o=0, issue_trans_id_o=0. Same sequence with rst_i=1 instead → identical outcome.
